fifo_wr_ptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the N-bit asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory. It accepts write requests, advances a binary/Gray write pointer, and supplies the memory with the write address and full flag. It also synchronizes the read-domain Gray pointer into the write clock domain to compute full, almost-full and fill level.

---
 rtl/fifo_wr_ptr_full_if.sv | 15 +
 rtl/fifo_wr_ptr_full.sv | 42 ++++
 tb/tb_fifo_wr_ptr_full.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ptr_full_if.sv
// fifo_wr_ptr_full_if: write requests, read-pointer input and status outputs of the FIFO write-side pointer block
interface fifo_wr_ptr_full_if #(parameter int ADDR_SIZE = 4);
    logic                 i_wr_en;
    logic [ADDR_SIZE:0]   i_rd_gptr;
    logic [ADDR_SIZE-1:0] o_wr_addr;
    logic [ADDR_SIZE:0]   o_wr_gptr;
    logic [ADDR_SIZE:0]   o_wr_count;
    logic                 o_full;
    logic                 o_almost_full;
    logic                 o_overflow;
    modport master(output i_wr_en, i_rd_gptr,
                   input o_wr_addr, o_wr_gptr, o_wr_count, o_full, o_almost_full, o_overflow);
    modport slave(input i_wr_en, i_rd_gptr,
                  output o_wr_addr, o_wr_gptr, o_wr_count, o_full, o_almost_full, o_overflow);
endinterface

// File: rtl/fifo_wr_ptr_full.sv
// fifo_wr_ptr_full: async FIFO write pointer, read-pointer synchronizer, full/almost-full/fill level
module fifo_wr_ptr_full #(
    parameter int ADDR_SIZE   = 4,
    parameter int AFULL_LEVEL = 14
) (
    input logic               i_wr_clk,
    input logic               i_wr_rst,
    fifo_wr_ptr_full_if.slave bus
);
    localparam int A = ADDR_SIZE;
    localparam logic [A:0] AF_LVL = AFULL_LEVEL[A:0];
    logic [A:0] wbin, wbin_next, gray_next, rq1, rq2, rbin;
    logic       wr_acc;
    assign wr_acc    = bus.i_wr_en & ~bus.o_full;
    assign wbin_next = wbin + {{A{1'b0}}, wr_acc};
    assign gray_next = (wbin_next >> 1) ^ wbin_next;
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= A; i++) rbin[i] = ^(rq2 >> i);
    end
    assign bus.o_wr_addr     = wbin[A-1:0];
    assign bus.o_wr_count    = wbin - rbin;
    assign bus.o_almost_full = bus.o_wr_count >= AF_LVL;
    // full uses the pre-edge rq2, so it can linger one cycle after a read lands
    always_ff @(posedge i_wr_clk) begin
        if (!i_wr_rst) begin
            wbin           <= '0;
            bus.o_wr_gptr  <= '0;
            rq1            <= '0;
            rq2            <= '0;
            bus.o_full     <= 1'b0;
            bus.o_overflow <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            bus.o_wr_gptr  <= gray_next;
            rq1            <= bus.i_rd_gptr;
            rq2            <= rq1;
            bus.o_full     <= gray_next == {~rq2[A:A-1], rq2[A-2:0]};
            bus.o_overflow <= bus.i_wr_en & bus.o_full;
        end
    end
endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb_fifo_wr_ptr_full: scoreboard bench for the FIFO write pointer / full flag block
module tb_fifo_wr_ptr_full;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    logic [16:0] sb[$];
    logic [16:0] e;
    logic [4:0]  m_wbin, m_rq1, m_rq2;
    logic        m_full, m_ovf;

    fifo_wr_ptr_full_if #(.ADDR_SIZE(4)) bus ();
    fifo_wr_ptr_full #(.ADDR_SIZE(4), .AFULL_LEVEL(14)) dut (.i_wr_clk(clk), .i_wr_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    wire [16:0] obs = {bus.o_wr_addr, bus.o_wr_gptr, bus.o_full, bus.o_almost_full, bus.o_wr_count, bus.o_overflow};

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // drive one edge and push what the outputs must look like after it
    task automatic cycle(input logic rst_n, input logic en, input logic [4:0] rd);
        logic [4:0] nb, cnt;
        rst = rst_n;
        bus.i_wr_en = en;
        bus.i_rd_gptr = rd;
        if (!rst_n) begin
            m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_ovf = 0;
        end else begin
            nb = m_wbin + {4'b0, en & ~m_full};
            m_ovf = en & m_full;
            m_full = (nb - g2b(m_rq2)) == 5'd16;
            m_rq2 = m_rq1;
            m_rq1 = rd;
            m_wbin = nb;
        end
        cnt = m_wbin - g2b(m_rq2);
        sb.push_back({m_wbin[3:0], m_wbin ^ (m_wbin >> 1), m_full, cnt >= 5'd14, cnt, m_ovf});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 5'b00101);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reset_sb[%0d] got=%h want=%h", i, obs, e); end
            total++;
            if (obs !== 17'd0) begin bad++; $display("FAIL reset_zero[%0d] got=%h want=0", i, obs); end
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b1, 5'd0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL fill_sb[%0d] got=%h want=%h", i, obs, e); end
            total++;
            if (bus.o_almost_full !== (i >= 14)) begin bad++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, bus.o_almost_full, i >= 14); end
            total++;
            if (bus.o_full !== (i == 16)) begin bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, bus.o_full, i == 16); end
        end
        total++;
        if (bus.o_wr_gptr !== 5'b11000 || bus.o_wr_count !== 5'd16 || bus.o_wr_addr !== 4'd0) begin
            bad++; $display("FAIL fill_end gptr=%b cnt=%0d addr=%0d want 11000/16/0", bus.o_wr_gptr, bus.o_wr_count, bus.o_wr_addr);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 5'd0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL ovf_sb[%0d] got=%h want=%h", i, obs, e); end
            total++;
            if (bus.o_overflow !== 1'b1 || bus.o_wr_gptr !== 5'b11000 || bus.o_wr_count !== 5'd16) begin
                bad++; $display("FAIL ovf_hold[%0d] ovf=%b gptr=%b cnt=%0d want 1/11000/16", i, bus.o_overflow, bus.o_wr_gptr, bus.o_wr_count);
            end
        end
    endtask

    task automatic test_release;
        logic [1:0] want_full [3] = '{2'b01, 2'b01, 2'b00};
        logic [4:0] want_cnt [3] = '{5'd16, 5'd15, 5'd15};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 5'b00001);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL rel_sb[%0d] got=%h want=%h", i, obs, e); end
            total++;
            if (bus.o_full !== want_full[i][0] || bus.o_wr_count !== want_cnt[i]) begin
                bad++; $display("FAIL rel_step[%0d] full=%b cnt=%0d want %b/%0d", i, bus.o_full, bus.o_wr_count, want_full[i][0], want_cnt[i]);
            end
        end
        cycle(1'b1, 1'b1, 5'b00001);
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL rel_write got=%h want=%h", obs, e); end
        total++;
        if (bus.o_full !== 1'b1 || bus.o_wr_addr !== 4'd1 || bus.o_overflow !== 1'b0) begin
            bad++; $display("FAIL rel_refull full=%b addr=%0d ovf=%b want 1/1/0", bus.o_full, bus.o_wr_addr, bus.o_overflow);
        end
    endtask

    task automatic test_mid_reset;
        cycle(1'b0, 1'b0, 5'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 5'd0);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL mid_sb[%0d] got=%h want=%h", i, obs, e); end
        end
        cycle(1'b0, 1'b1, 5'd0);
        e = sb.pop_front();
        total++;
        if (obs !== e || obs !== 17'd0) begin bad++; $display("FAIL mid_rst got=%h want=%h", obs, e); end
        cycle(1'b1, 1'b1, 5'd0);
        e = sb.pop_front();
        total++;
        if (obs !== e || bus.o_wr_addr !== 4'd1 || bus.o_wr_gptr !== 5'b00001) begin
            bad++; $display("FAIL mid_after got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_wrap;
        logic [4:0] prev, lag;
        logic       wrapped = 1'b0;
        cycle(1'b0, 1'b0, 5'd0);
        void'(sb.pop_front());
        prev = 5'd0;
        for (int i = 1; i <= 40; i++) begin
            lag = (m_wbin == 5'd0) ? 5'd0 : m_wbin - 5'd1;
            cycle(1'b1, 1'b1, lag ^ (lag >> 1));
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL wrap_sb[%0d] got=%h want=%h", i, obs, e); end
            total++;
            if (bus.o_full !== 1'b0 || bus.o_wr_count > 5'd3 || $countones(bus.o_wr_gptr ^ prev) != 1) begin
                bad++; $display("FAIL wrap_step[%0d] full=%b cnt=%0d gptr=%b prev=%b", i, bus.o_full, bus.o_wr_count, bus.o_wr_gptr, prev);
            end
            if (i == 32) begin
                wrapped = 1'b1;
                total++;
                if (prev !== 5'b10000 || bus.o_wr_gptr !== 5'b00000) begin
                    bad++; $display("FAIL wrap_edge prev=%b gptr=%b want 10000->00000", prev, bus.o_wr_gptr);
                end
            end
            prev = bus.o_wr_gptr;
        end
        total++;
        if (!wrapped || bus.o_wr_addr !== 4'd8) begin bad++; $display("FAIL wrap_end addr=%0d want 8", bus.o_wr_addr); end
    endtask

    initial begin
        rst = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_rd_gptr = '0;
        @(posedge clk);
        #1;
        test_reset;
        test_fill;
        test_overflow;
        test_release;
        test_mid_reset;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
